udp_ip_eth_tx_framer: RTL
=========================

# udp_ip_eth_tx_framer

Transmit framer directly downstream of the TX payload FIFO: on a frame-start request it builds a 42-byte Ethernet II + IPv4 + UDP header, with the IPv4 header checksum computed in hardware. It streams the header bytes to the MAC, pulses `udp_header_tx_done`, then serializes the 32-bit payload words big-endian into the same 8-bit output stream. Preamble, padding to 60 bytes and FCS are the MAC's job.

## Interface
- `IP_TTL`, 64: IPv4 TTL field.
- `ETH_TYPE`, 16'h0800: EtherType field.
- `aclk` in 1: single clock, all logic rising-edge.
- `areset` in 1: synchronous, active-high reset.
- `eth_header_ip_tx_start` in 1: frame request, level, held until `udp_header_tx_done`.
- `udp_len` in 16: UDP payload bytes (multiple of 4); sampled with start.
- `udp_header_tx_done` out 1: one-cycle pulse after the last header byte is accepted.
- `src_mac`, `dst_mac` in 48: MAC addresses; sampled with start.
- `src_ip`, `dst_ip` in 32: IPv4 addresses; sampled with start.
- `src_port`, `dst_port` in 16: UDP ports; sampled with start.
- `s_axis_tdata` in 32, `s_axis_tvalid` in 1, `s_axis_tlast` in 1, `s_axis_tready` out 1: payload words from the FIFO.
- `m_axis_tdata` out 8, `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tready` in 1: byte stream to the MAC.
- `len_err` out 1: one-cycle pulse when the payload word count at `s_axis_tlast` differs from `udp_len/4`.

## Operation
- States: IDLE, CSUM, FOLD, HDR, PAYLOAD.
- IDLE: when `eth_header_ip_tx_start`=1, latch all config ports and `udp_len`, clear accumulator, go to CSUM. Start is ignored in every other state.
- CSUM: 10 cycles. Each cycle adds one IPv4 header 16-bit word (checksum field = 0) into a 20-bit accumulator. Words in order: 4500, total_len, ident, 4000, {IP_TTL,8'h11}, 0000, src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0].
- FOLD: 1 cycle. csum = ~(acc[15:0] + acc[19:16] + carry), folded twice so the result is a true one's-complement sum. Then go to HDR.
- total_len = udp_len + 28; udp_length = udp_len + 8 (16-bit, wrap ignored). ident is a 16-bit counter: 0 after reset, +1 per completed frame.
- HDR: emit 42 bytes, index 0..41, advancing only on `m_axis_tvalid && m_axis_tready`. Byte order:
  - dst_mac, src_mac, ETH_TYPE
  - 45, 00, total_len, ident, 40, 00, IP_TTL, 11, csum, src_ip, dst_ip
  - src_port, dst_port, udp_length, 00, 00
  - All fields MSB first.
- On acceptance of byte 41: pulse `udp_header_tx_done` the next cycle and enter PAYLOAD.
- PAYLOAD: accept word into a holding register, then emit bytes [31:24], [23:16], [15:8], [7:0].
  - `s_axis_tready` (combinational) = PAYLOAD && (holding empty || (byte 3 being accepted && held word not last)). This gives gapless streaming.
  - `m_axis_tlast`=1 on byte 3 of the word that carried `s_axis_tlast`.
  - After that byte is accepted, increment ident and return to IDLE.
  - Count words; on the tlast word, if count ≠ `udp_len[15:2]`, pulse `len_err`. The frame still ends on tlast.
- `udp_len`=0: header only; the first payload word must carry tlast. No zero-payload shortcut.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `udp_header_tx_done`, `len_err`, `s_axis_tready` = 0; `m_axis_tdata` = 0; state IDLE; ident 0.
- Start sampled in cycle T: CSUM T+1..T+10, FOLD T+11, `m_axis_tvalid`=1 with byte 0 in T+12.
- Minimum header time 42 cycles with `m_axis_tready` held high.
- `m_axis_tdata`/`m_axis_tlast` hold stable while `m_axis_tvalid && !m_axis_tready`. `m_axis_tvalid` never drops mid-header.
- `m_axis_tvalid` may drop between payload words only when `s_axis_tvalid` is low.
- Done pulse occurs while start is still high; start is not re-sampled until IDLE, so a held start cannot retrigger the same frame.
- Back-to-back frames: IDLE lasts at least 1 cycle between `m_axis_tlast` acceptance and the next CSUM.
- `areset` mid-frame: the next cycle returns to IDLE with all outputs at reset values; the partial frame is dropped. ident resets to 0.

## Test plan
- src 192.168.1.10, dst 192.168.1.1, udp_len 16, ident 0, tready=1 -> header bytes 14..33 = 45 00 00 2C 00 00 40 00 40 11 B7 65 C0 A8 01 0A C0 A8 01 01; UDP length bytes 38..39 = 00 18; first tvalid at T+12.
- Payload words 0x01020304, 0x05060708 (tlast), udp_len 8 -> bytes 01..08 follow the header, tlast on 08, single done pulse, no len_err, ident 1 in the next frame.
- Random `m_axis_tready` (50%) over a 64-word frame -> byte stream identical to the tready=1 run; data stable during stalls; no byte dropped or duplicated.
- udp_len 16 but tlast on word 3 -> frame ends after 12 payload bytes, `len_err` pulses once, block returns to IDLE.
- `areset` asserted at header byte 20 -> next cycle tvalid=0, state IDLE; a fresh start produces a complete frame with ident 0.
- Start held high through two frames with the FIFO feeding continuously -> exactly one header per frame, ident 0 then 1, checksum recomputed (ident change reflected).

Source files
------------

// File: rtl/udp_ip_eth_tx_framer_if.sv
// -----------------------------------------------------------------------------
// udp_ip_eth_tx_framer_if
// Valid/ready byte- or word-stream bundle used on both sides of the framer.
//   tdata  : stream data, DATA_W bits wide
//   tvalid : source has data on tdata
//   tlast  : current beat closes the packet
//   tready : sink accepts the beat this cycle
// master drives data/valid/last and observes ready; slave is the mirror.
// -----------------------------------------------------------------------------
interface udp_ip_eth_tx_framer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_ip_eth_tx_framer.sv
// -----------------------------------------------------------------------------
// udp_ip_eth_tx_framer
// Builds a 42-byte Ethernet II + IPv4 + UDP header (IPv4 checksum computed
// here), streams it byte by byte, then serializes 32-bit payload words
// big-endian into the same 8-bit stream.
// Ports:
//   aclk, areset            : clock, synchronous active-high reset
//   eth_header_ip_tx_start  : frame request level, held until done
//   udp_len                 : UDP payload length in bytes (multiple of 4)
//   udp_header_tx_done      : one-cycle pulse after the last header byte
//   src_mac/dst_mac, src_ip/dst_ip, src_port/dst_port : header fields
//   s_axis (slave, 32 bit)  : payload words from the TX FIFO
//   m_axis (master, 8 bit)  : byte stream to the MAC
//   len_err                 : pulse when the tlast word count != udp_len/4
// -----------------------------------------------------------------------------
module udp_ip_eth_tx_framer #(
  parameter logic [7:0]  IP_TTL   = 8'd64,
  parameter logic [15:0] ETH_TYPE = 16'h0800
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   eth_header_ip_tx_start,
  input  logic [15:0]            udp_len,
  output logic                   udp_header_tx_done,
  input  logic [47:0]            src_mac,
  input  logic [47:0]            dst_mac,
  input  logic [31:0]            src_ip,
  input  logic [31:0]            dst_ip,
  input  logic [15:0]            src_port,
  input  logic [15:0]            dst_port,
  udp_ip_eth_tx_framer_if.slave  s_axis,
  udp_ip_eth_tx_framer_if.master m_axis,
  output logic                   len_err
);

  typedef enum logic [2:0] {IDLE, CSUM, FOLD, HDR, PAYLOAD} state_t;

  state_t      state_q, state_d;
  logic [3:0]  csum_cnt_q, csum_cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] csum_q, csum_d;
  logic [5:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] ident_q, ident_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [23:0] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        hold_last_q, hold_last_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [13:0] word_cnt_q, word_cnt_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic        done_q, done_d;
  logic        len_err_q, len_err_d;

  logic [15:0]  total_len;
  logic [15:0]  udp_length;
  logic [335:0] hdr_vec;
  logic [5:0]   hdr_idx_nxt;
  logic [8:0]   hdr_sel;
  logic [7:0]   hdr_byte_nxt;
  logic [15:0]  csum_word;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [7:0]   pay_byte_nxt;
  logic         m_acc;
  logic         s_ready;
  logic         s_acc;

  assign m_axis.tdata       = m_tdata_q;
  assign m_axis.tvalid      = m_tvalid_q;
  assign m_axis.tlast       = m_tlast_q;
  assign s_axis.tready      = s_ready;
  assign udp_header_tx_done = done_q;
  assign len_err            = len_err_q;

  // Header image and its byte selector. The whole header is laid out MSB
  // first so header byte k sits at bits [335-8k -: 8]; the selector always
  // looks one byte ahead because the output register is loaded on acceptance.
  // The fold adds the accumulator's carry nibble back in twice: the first add
  // can itself carry out of bit 15, the second cannot.
  always_comb begin
    total_len    = udp_len_q + 16'd28;
    udp_length   = udp_len_q + 16'd8;
    hdr_vec      = {dst_mac_q, src_mac_q, ETH_TYPE,
                    8'h45, 8'h00, total_len, ident_q, 8'h40, 8'h00,
                    IP_TTL, 8'h11, csum_q, src_ip_q, dst_ip_q,
                    src_port_q, dst_port_q, udp_length, 16'h0000};
    hdr_idx_nxt  = hdr_idx_q + 6'd1;
    hdr_sel      = 9'd328 - {hdr_idx_nxt, 3'b000};
    hdr_byte_nxt = hdr_vec[hdr_sel +: 8];
    fold1        = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    fold2        = fold1[15:0] + {15'd0, fold1[16]};
    case (csum_cnt_q)
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = total_len;
      4'd2:    csum_word = ident_q;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {IP_TTL, 8'h11};
      4'd6:    csum_word = src_ip_q[31:16];
      4'd7:    csum_word = src_ip_q[15:0];
      4'd8:    csum_word = dst_ip_q[31:16];
      4'd9:    csum_word = dst_ip_q[15:0];
      default: csum_word = 16'h0000;
    endcase
    case (byte_idx_q)
      2'd0:    pay_byte_nxt = hold_q[23:16];
      2'd1:    pay_byte_nxt = hold_q[15:8];
      default: pay_byte_nxt = hold_q[7:0];
    endcase
  end

  // Payload handshakes. A new word is taken either into an empty holding
  // register or in the same cycle its predecessor's last byte leaves, which
  // keeps the byte stream gapless while the FIFO has data. The tlast word is
  // never overlapped so the frame ends cleanly before the next request.
  always_comb begin
    m_acc   = m_tvalid_q && m_axis.tready;
    s_ready = (state_q == PAYLOAD) &&
              (!hold_valid_q || (m_acc && (byte_idx_q == 2'd3) && !hold_last_q));
    s_acc   = s_ready && s_axis.tvalid;
  end

  // Next-state logic for the frame sequencer: request latch, ten-cycle
  // checksum accumulation, fold, 42 header bytes, then payload words until
  // the tlast word has fully drained.
  always_comb begin
    state_d      = state_q;
    csum_cnt_d   = csum_cnt_q;
    acc_d        = acc_q;
    csum_d       = csum_q;
    hdr_idx_d    = hdr_idx_q;
    ident_d      = ident_q;
    udp_len_d    = udp_len_q;
    src_mac_d    = src_mac_q;
    dst_mac_d    = dst_mac_q;
    src_ip_d     = src_ip_q;
    dst_ip_d     = dst_ip_q;
    src_port_d   = src_port_q;
    dst_port_d   = dst_port_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    m_tdata_d    = m_tdata_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    done_d       = 1'b0;
    len_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (eth_header_ip_tx_start) begin
          udp_len_d  = udp_len;
          src_mac_d  = src_mac;
          dst_mac_d  = dst_mac;
          src_ip_d   = src_ip;
          dst_ip_d   = dst_ip;
          src_port_d = src_port;
          dst_port_d = dst_port;
          acc_d      = 20'd0;
          csum_cnt_d = 4'd0;
          word_cnt_d = 14'd0;
          state_d    = CSUM;
        end
      end

      CSUM: begin
        acc_d      = acc_q + {4'd0, csum_word};
        csum_cnt_d = csum_cnt_q + 4'd1;
        if (csum_cnt_q == 4'd9) begin
          state_d = FOLD;
        end
      end

      FOLD: begin
        csum_d     = ~fold2;
        hdr_idx_d  = 6'd0;
        m_tdata_d  = hdr_vec[335:328];
        m_tvalid_d = 1'b1;
        m_tlast_d  = 1'b0;
        state_d    = HDR;
      end

      HDR: begin
        if (m_acc) begin
          if (hdr_idx_q == 6'd41) begin
            m_tvalid_d   = 1'b0;
            hold_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = PAYLOAD;
          end else begin
            hdr_idx_d = hdr_idx_nxt;
            m_tdata_d = hdr_byte_nxt;
          end
        end
      end

      PAYLOAD: begin
        if (m_acc) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            m_tdata_d  = pay_byte_nxt;
            m_tlast_d  = hold_last_q && (byte_idx_q == 2'd2);
          end else begin
            hold_valid_d = 1'b0;
            m_tvalid_d   = 1'b0;
            m_tlast_d    = 1'b0;
            if (hold_last_q) begin
              ident_d = ident_q + 16'd1;
              state_d = IDLE;
            end
          end
        end
        if (s_acc) begin
          hold_d       = s_axis.tdata[23:0];
          hold_valid_d = 1'b1;
          hold_last_d  = s_axis.tlast;
          byte_idx_d   = 2'd0;
          m_tdata_d    = s_axis.tdata[31:24];
          m_tvalid_d   = 1'b1;
          m_tlast_d    = 1'b0;
          word_cnt_d   = word_cnt_q + 14'd1;
          if (s_axis.tlast && ((word_cnt_q + 14'd1) != udp_len_q[15:2])) begin
            len_err_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // All state and outputs are registered here; reset drops any partial frame
  // and restarts the IP identification counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      csum_cnt_q   <= 4'd0;
      acc_q        <= 20'd0;
      csum_q       <= 16'd0;
      hdr_idx_q    <= 6'd0;
      ident_q      <= 16'd0;
      udp_len_q    <= 16'd0;
      src_mac_q    <= 48'd0;
      dst_mac_q    <= 48'd0;
      src_ip_q     <= 32'd0;
      dst_ip_q     <= 32'd0;
      src_port_q   <= 16'd0;
      dst_port_q   <= 16'd0;
      hold_q       <= 24'd0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      byte_idx_q   <= 2'd0;
      word_cnt_q   <= 14'd0;
      m_tdata_q    <= 8'd0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      csum_cnt_q   <= csum_cnt_d;
      acc_q        <= acc_d;
      csum_q       <= csum_d;
      hdr_idx_q    <= hdr_idx_d;
      ident_q      <= ident_d;
      udp_len_q    <= udp_len_d;
      src_mac_q    <= src_mac_d;
      dst_mac_q    <= dst_mac_d;
      src_ip_q     <= src_ip_d;
      dst_ip_q     <= dst_ip_d;
      src_port_q   <= src_port_d;
      dst_port_q   <= dst_port_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      done_q       <= done_d;
      len_err_q    <= len_err_d;
    end
  end

endmodule
